// File: rtl/bitstream_self_writer.sv
// ---------------------------------------------------------------------------
// bitstream_self_writer
//
// Reads a configuration bitstream byte-by-byte from a synchronous byte memory.
// It packs each group of four bytes into one big-endian 32-bit word (the first
// byte becomes the MSB). Each word is presented to the fabric's self-write port
// with a programmable setup gap, a single-cycle strobe and a programmable hold
// gap.
//
// Ports
//   CLK              in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   start            in   begin a load (sampled only while idle)
//   num_bytes        in   bitstream length in bytes, latched on start
//   mem_rd_en        out  byte memory read enable
//   mem_addr         out  byte memory address
//   mem_rdata        in   byte read data, one cycle after mem_rd_en
//   SelfWriteData    out  configuration word to the fabric
//   SelfWriteStrobe  out  one-cycle write pulse to the fabric
//   busy             out  high from accepted start until the done pulse
//   done             out  one-cycle pulse after the final word's hold
//   word_count       out  words written in the current/last load
// ---------------------------------------------------------------------------
module bitstream_self_writer #(
    parameter int ADDR_W       = 14,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_bytes,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] word_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam int                CNT_W      = 16;
    localparam logic [CNT_W-1:0]  FETCH_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]   WORD_BYTES = (ADDR_W+1)'(4);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;          // cycle index within the current state
    logic [ADDR_W:0]   ptr;          // byte address of the current word
    logic [ADDR_W:0]   nb;           // latched bitstream length
    logic [ADDR_W:0]   rd_ptr;       // byte address issued this FETCH cycle
    logic [31:8]       shadow;       // first three bytes of the word being fetched
    logic              rd_q;         // a read was issued last cycle
    logic [7:0]        cap_byte;     // byte arriving this cycle (0 for padding)
    logic              more_words;
    logic              word_end;     // last cycle of the current word

    assign rd_ptr     = ptr + (ADDR_W+1)'(cnt[1:0]);
    assign more_words = (ptr + WORD_BYTES) < nb;
    // Bytes past the end of the bitstream were never read; pad them with zero.
    assign cap_byte   = rd_q ? mem_rdata : 8'h00;

    // Next-state and outputs
    always_comb begin
        state_next      = state;
        word_end        = 1'b0;
        mem_rd_en       = 1'b0;
        mem_addr        = '0;
        SelfWriteStrobe = 1'b0;
        busy            = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_bytes == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (cnt < FETCH_LAST) begin
                    mem_addr  = rd_ptr[ADDR_W-1:0];
                    mem_rd_en = (rd_ptr < nb);
                end
                if (cnt == FETCH_LAST) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                SelfWriteStrobe = 1'b1;
                if (HOLD_CYCLES == 0) begin
                    word_end = 1'b1;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    word_end = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (word_end) begin
            state_next = more_words ? FETCH : DONE;
        end
    end

    // State register and datapath
    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= '0;
            nb            <= '0;
            shadow        <= '0;
            rd_q          <= 1'b0;
            done          <= 1'b0;
            word_count    <= '0;
            SelfWriteData <= '0;
        end else begin
            state <= state_next;
            rd_q  <= mem_rd_en;
            // done is issued on the DONE->IDLE edge so busy is already low.
            done  <= (state == DONE);

            // Every transition changes state, so a state change restarts the count.
            if ((state_next != state) || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if ((state == IDLE) && start) begin
                nb         <= num_bytes;
                ptr        <= '0;
                word_count <= '0;
            end

            // Byte k arrives on FETCH cycle k+1; the last byte goes straight
            // into the output word together with the shadowed upper bytes.
            if (state == FETCH) begin
                case (cnt[2:0])
                    3'd1:    shadow[31:24] <= cap_byte;
                    3'd2:    shadow[23:16] <= cap_byte;
                    3'd3:    shadow[15:8]  <= cap_byte;
                    3'd4:    SelfWriteData <= {shadow[31:8], cap_byte};
                    default: ;
                endcase
            end

            if (state == STROBE) begin
                word_count <= word_count + (ADDR_W-1)'(1);
            end

            if (word_end) begin
                ptr <= ptr + WORD_BYTES;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_self_writer.sv
// ---------------------------------------------------------------------------
// tb_bitstream_self_writer
//
// Directed bench for bitstream_self_writer at default parameters. It contains a
// synchronous byte memory model and a negedge monitor that records strobed
// words and timing. A table of short loads is followed by hand-written abort
// and full-memory sequences.
// ---------------------------------------------------------------------------
module tb_bitstream_self_writer;

    localparam int ADDR_W = 14;
    localparam int SETUP  = 2;
    localparam int HOLD   = 2;
    localparam int PERIOD = 5 + SETUP + 1 + HOLD;

    logic              CLK;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   num_bytes;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       SelfWriteData;
    logic              SelfWriteStrobe;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] word_count;

    bitstream_self_writer #(
        .ADDR_W      (ADDR_W),
        .SETUP_CYCLES(SETUP),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .num_bytes      (num_bytes),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .SelfWriteData  (SelfWriteData),
        .SelfWriteStrobe(SelfWriteStrobe),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous byte memory; returns junk when not read so padding matters.
    logic [7:0] mem [0:16383];
    always @(posedge CLK) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'hA5;
    end

    // Monitor
    int          ncyc = 0;
    int          last_strobe_cyc = 0;
    bit          seen_strobe = 0;
    int          data_stable = 0;
    logic [31:0] prev_data = '0;
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    int          setup_viol = 0;
    int          hold_viol = 0;
    int          b2b_viol = 0;
    int          oob = 0;
    int          last_period = 0;
    logic [ADDR_W:0] cur_nb = '0;
    logic [31:0] sq[$];

    always @(negedge CLK) begin
        ncyc++;
        if (SelfWriteData != prev_data) begin
            if (seen_strobe && (ncyc - last_strobe_cyc) <= HOLD) hold_viol++;
            data_stable = 0;
        end else begin
            data_stable++;
        end
        prev_data = SelfWriteData;
        if (SelfWriteStrobe) begin
            strobe_cnt++;
            sq.push_back(SelfWriteData);
            if (data_stable < SETUP) setup_viol++;
            if (seen_strobe) begin
                last_period = ncyc - last_strobe_cyc;
                if (last_period < 2) b2b_viol++;
            end
            last_strobe_cyc = ncyc;
            seen_strobe = 1;
        end
        if (done) done_cnt++;
        if (mem_rd_en && ({1'b0, mem_addr} >= cur_nb)) oob++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one clock, then wait (bounded) for done. lat counts
    // clock edges from the one that samples start to the one raising done.
    task automatic run_load(input logic [ADDR_W:0] nb, input int budget, output int lat);
        @(negedge CLK);
        cur_nb    = nb;
        num_bytes = nb;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < budget) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    typedef struct {
        logic [ADDR_W:0] nb;
        logic [63:0]     bytes;
        logic [31:0]     w0;
        logic [31:0]     w1;
        int              nw;
        int              lat;
    } vec_t;

    localparam int NV = 5;
    vec_t vt [NV];

    initial begin
        int lat;
        int s0;
        int d0;
        int werr;
        logic [31:0] exp_w;

        vt[0] = '{nb: 15'd8, bytes: 64'hDEADBEEF01020304, w0: 32'hDEADBEEF, w1: 32'h01020304, nw: 2, lat: 22};
        vt[1] = '{nb: 15'd6, bytes: 64'hAABBCCDDEEFF1122, w0: 32'hAABBCCDD, w1: 32'hEEFF0000, nw: 2, lat: 22};
        vt[2] = '{nb: 15'd0, bytes: 64'h1111111111111111, w0: 32'h0,        w1: 32'h0,        nw: 0, lat: 2};
        vt[3] = '{nb: 15'd1, bytes: 64'h12345678AABBCCDD, w0: 32'h12000000, w1: 32'h0,        nw: 1, lat: 12};
        vt[4] = '{nb: 15'd5, bytes: 64'h1122334455667788, w0: 32'h11223344, w1: 32'h55000000, nw: 2, lat: 22};

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

        // Reset
        reset     = 1'b1;
        start     = 1'b0;
        num_bytes = '0;
        repeat (3) @(negedge CLK);
        check("rst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
        check("rst_mem_addr", {50'd0, mem_addr}, 64'd0);
        check("rst_data", {32'd0, SelfWriteData}, 64'd0);
        check("rst_strobe", {63'd0, SelfWriteStrobe}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_word_count", {51'd0, word_count}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        // Table of short loads
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 8; k++) mem[k] = vt[v].bytes[63-8*k -: 8];
            sq.delete();
            s0 = strobe_cnt;
            d0 = done_cnt;
            run_load(vt[v].nb, 200, lat);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vt[v].lat));
            check($sformatf("v%0d_busy_at_done", v), {63'd0, busy}, 64'd0);
            @(negedge CLK);
            #1;
            check($sformatf("v%0d_strobes", v), 64'(strobe_cnt - s0), 64'(vt[v].nw));
            check($sformatf("v%0d_done_pulses", v), 64'(done_cnt - d0), 64'd1);
            check($sformatf("v%0d_word_count", v), {51'd0, word_count}, 64'(vt[v].nw));
            check($sformatf("v%0d_busy_after", v), {63'd0, busy}, 64'd0);
            if (vt[v].nw >= 1)
                check($sformatf("v%0d_word0", v), {32'd0, (sq.size() > 0) ? sq[0] : 32'hFFFFFFFF}, {32'd0, vt[v].w0});
            if (vt[v].nw >= 2) begin
                check($sformatf("v%0d_word1", v), {32'd0, (sq.size() > 1) ? sq[1] : 32'hFFFFFFFF}, {32'd0, vt[v].w1});
                check($sformatf("v%0d_strobe_period", v), 64'(last_period), 64'(PERIOD));
            end
            if (vt[v].nw >= 1)
                check($sformatf("v%0d_data_held", v), {32'd0, SelfWriteData}, {32'd0, (vt[v].nw == 1) ? vt[v].w0 : vt[v].w1});
            repeat (3) @(negedge CLK);
        end
        check("table_out_of_range_reads", 64'(oob), 64'd0);

        // Re-pulsed start ignored, then reset during second word's SETUP
        for (int k = 0; k < 16; k++) mem[k] = 8'(8'h40 + k);
        sq.delete();
        s0 = strobe_cnt;
        d0 = done_cnt;
        @(negedge CLK);
        cur_nb    = 15'd16;
        num_bytes = 15'd16;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat   = 0;
        while (!SelfWriteStrobe && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        check("abort_first_word", {32'd0, SelfWriteData}, {32'd0, 32'h40414243});
        @(negedge CLK);
        num_bytes = 15'd4;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        check("abort_busy_kept", {63'd0, busy}, 64'd1);
        check("abort_wc_kept", {51'd0, word_count}, 64'd1);
        @(negedge CLK);
        check("abort_in_setup", {32'd0, SelfWriteData}, {32'd0, 32'h44454647});
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        repeat (30) @(negedge CLK);
        #1;
        check("abort_strobes", 64'(strobe_cnt - s0), 64'd1);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle", {63'd0, busy}, 64'd0);
        check("abort_wc_cleared", {51'd0, word_count}, 64'd0);

        // Full memory load
        for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 37) ^ (i >> 6));
        sq.delete();
        s0 = strobe_cnt;
        d0 = done_cnt;
        run_load(15'd16384, 50000, lat);
        check("full_latency", 64'(lat), 64'(PERIOD * 4096 + 2));
        @(negedge CLK);
        #1;
        check("full_strobes", 64'(strobe_cnt - s0), 64'd4096);
        check("full_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("full_word_count", {51'd0, word_count}, 64'd4096);
        werr = 0;
        for (int j = 0; j < 4096; j++) begin
            exp_w = {mem[4*j], mem[4*j+1], mem[4*j+2], mem[4*j+3]};
            if (j >= sq.size() || sq[j] !== exp_w) werr++;
        end
        check("full_word_mismatches", 64'(werr), 64'd0);
        check("setup_violations", 64'(setup_viol), 64'd0);
        check("hold_violations", 64'(hold_viol), 64'd0);
        check("back_to_back_strobes", 64'(b2b_viol), 64'd0);
        check("full_out_of_range_reads", 64'(oob), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
